fft_output_streamer: RTL and testbench

Downstream stage of the 256-point FFT core. Accepts the 256 complex results of one transform as indexed writes in any order, holds them in a single frame buffer, then streams them out in natural order (index 0..255) over a valid/ready interface. Each output is narrowed from the internal 30-bit format back to the 20-bit external format by rounding off the two guard LSBs that the input stage appends.

---
 rtl/fft_output_streamer_if.sv | 42 ++++
 rtl/fft_output_streamer.sv | 224 ++++++++++++++++++++++
 tb/tb_fft_output_streamer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_output_streamer_if.sv
// fft_output_streamer_if
// Handshake bundle between the FFT core, the output streamer and the
// downstream consumer.
//
//   Write side : in_valid, in_ready, in_index[7:0], in_real, in_imag
//                (signed, totalbits wide)
//   Read side  : out_valid, out_ready, out_index[7:0], out_real, out_imag
//                (signed, total_out_bits wide), out_last, frame_done
//
// Modports
//   master : the environment around the streamer (writes results, accepts beats)
//   slave  : the streamer itself
interface fft_output_streamer_if #(
    parameter int totalbits      = 30,
    parameter int total_out_bits = 20
);
    logic                             in_valid;
    logic                             in_ready;
    logic [7:0]                       in_index;
    logic signed [totalbits-1:0]      in_real;
    logic signed [totalbits-1:0]      in_imag;

    logic                             out_valid;
    logic                             out_ready;
    logic signed [total_out_bits-1:0] out_real;
    logic signed [total_out_bits-1:0] out_imag;
    logic [7:0]                       out_index;
    logic                             out_last;
    logic                             frame_done;

    modport master (
        output in_valid, in_index, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_real, out_imag, out_index,
               out_last, frame_done
    );

    modport slave (
        input  in_valid, in_index, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_real, out_imag, out_index,
               out_last, frame_done
    );
endinterface

// File: rtl/fft_output_streamer.sv
// fft_output_streamer
// Collects the 256 complex results of one FFT transform, written by index in
// any order, into a single frame buffer, then streams them out in natural
// order 0..255 over a valid/ready interface. Each sample is narrowed from the
// internal totalbits format to total_out_bits by rounding off the two guard
// LSBs: r = (x + 2) >>> 2.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   reset  : asynchronous, active-high
//   bus    : fft_output_streamer_if.slave (write side and stream side)
//
// Build option
//   FFT_OUT_SAT_EN : when defined, narrowed samples saturate to the signed
//                    total_out_bits range; otherwise the low bits are kept
//                    (wrap).
//
// States
//   IDLE  | buffer empty, wr_cnt = 0, waiting for the first write
//   FILL  | at least one write accepted, collecting the rest of the frame
//   DRAIN | write side closed, streaming entries 0..255 out
//
// Read path: the buffer is read through a registered prefetch stage (pf_*)
// so the arrays map onto synchronous RAM. The prefetch stage plus the output
// register form a two-deep pipeline, which gives full throughput under
// out_ready = 1 and a first beat two edges after the frame completes.
module fft_output_streamer #(
    parameter int totalbits      = 30,
    parameter int total_out_bits = 20
) (
    input logic                 clk,
    input logic                 reset,
    fft_output_streamer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic signed [totalbits-1:0] mem_re [256];
    logic signed [totalbits-1:0] mem_im [256];

    logic [7:0] wr_cnt;
    logic [8:0] rd_ptr;     // bit 8 set once entry 255 has been fetched

    logic                        pf_valid;
    logic [7:0]                  pf_index;
    logic signed [totalbits-1:0] pf_re;
    logic signed [totalbits-1:0] pf_im;

    logic                             out_valid;
    logic                             out_last;
    logic [7:0]                       out_index;
    logic signed [total_out_bits-1:0] out_real;
    logic signed [total_out_bits-1:0] out_imag;
    logic                             frame_done;

    logic in_ready;
    logic wr_acc;
    logic last_write;
    logic out_load;
    logic pf_adv;
    logic final_fire;

`ifdef FFT_OUT_SAT_EN
    localparam logic signed [totalbits-1:0] SAT_MAX =
        {{(totalbits-total_out_bits+1){1'b0}}, {(total_out_bits-1){1'b1}}};
    localparam logic signed [totalbits-1:0] SAT_MIN =
        {{(totalbits-total_out_bits+1){1'b1}}, {(total_out_bits-1){1'b0}}};
`endif

    // Round half up on the two guard bits. The sum is kept at totalbits, so
    // an input within 2 of the positive limit wraps before the shift.
    function automatic logic signed [total_out_bits-1:0] narrow(
        input logic signed [totalbits-1:0] x
    );
        logic signed [totalbits-1:0] sum;
`ifdef FFT_OUT_SAT_EN
        logic signed [totalbits-1:0] r;
`endif
        sum = x + {{(totalbits-2){1'b0}}, 2'b10};
`ifdef FFT_OUT_SAT_EN
        r = sum >>> 2;
        if (r > SAT_MAX) begin
            r = SAT_MAX;
        end else if (r < SAT_MIN) begin
            r = SAT_MIN;
        end
        return r[total_out_bits-1:0];
`else
        return total_out_bits'(sum >>> 2);
`endif
    endfunction

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        in_ready   = (state != DRAIN);
        wr_acc     = bus.in_valid && in_ready;
        last_write = 1'b0;
        final_fire = out_valid && bus.out_ready && out_last;
        out_load   = 1'b0;
        pf_adv     = 1'b0;

        case (state)
            IDLE: begin
                if (wr_acc) begin
                    state_nx = FILL;
                end
            end
            FILL: begin
                if (wr_acc && (wr_cnt == 8'd255)) begin
                    last_write = 1'b1;
                    state_nx   = DRAIN;
                end
            end
            DRAIN: begin
                // Output register takes the prefetched entry whenever it is
                // empty or its current beat is being accepted.
                out_load = pf_valid && (!out_valid || bus.out_ready);
                // Prefetch refills when empty or when it is being emptied.
                pf_adv   = !rd_ptr[8] && (!pf_valid || out_load);
                if (final_fire) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame buffer (not reset; unwritten slots hold stale data)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_re[bus.in_index] <= bus.in_real;
            mem_im[bus.in_index] <= bus.in_imag;
        end
    end

    always_ff @(posedge clk) begin
        if (pf_adv) begin
            pf_re <= mem_re[rd_ptr[7:0]];
            pf_im <= mem_im[rd_ptr[7:0]];
        end
    end

    // ------------------------------------------------------------------
    // Counters, prefetch control and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt     <= 8'd0;
            rd_ptr     <= 9'd0;
            pf_valid   <= 1'b0;
            pf_index   <= 8'd0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_index  <= 8'd0;
            out_real   <= '0;
            out_imag   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= final_fire;

            if (wr_acc) begin
                wr_cnt <= wr_cnt + 8'd1;
            end

            if (last_write || final_fire) begin
                rd_ptr <= 9'd0;
            end else if (pf_adv) begin
                rd_ptr <= rd_ptr + 9'd1;
            end

            if (pf_adv) begin
                pf_valid <= 1'b1;
                pf_index <= rd_ptr[7:0];
            end else if (out_load) begin
                pf_valid <= 1'b0;
            end

            if (out_load) begin
                out_valid <= 1'b1;
                out_index <= pf_index;
                out_last  <= (pf_index == 8'd255);
                out_real  <= narrow(pf_re);
                out_imag  <= narrow(pf_im);
            end else if (final_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_last   = out_last;
    assign bus.out_index  = out_index;
    assign bus.out_real   = out_real;
    assign bus.out_imag   = out_imag;
    assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_fft_output_streamer.sv
module tb_fft_output_streamer;

    localparam int TB = 30;
    localparam int OB = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fft_output_streamer_if #(.totalbits(TB), .total_out_bits(OB)) bus();

    fft_output_streamer #(.totalbits(TB), .total_out_bits(OB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int                     idx;
        logic signed [OB-1:0]   re;
        logic signed [OB-1:0]   im;
    } beat_t;

    beat_t                sb[$];
    logic signed [TB-1:0] m_re [256];
    logic signed [TB-1:0] m_im [256];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Independent reference: floor((x + 2) / 4) in 64-bit integer math.
    function automatic logic signed [OB-1:0] exp_narrow(input logic signed [TB-1:0] x);
        longint v;
        longint r;
        v = longint'(x) + 2;
        if (v >= 0) r = v / 4;
        else        r = -((-v + 3) / 4);
`ifdef FFT_OUT_SAT_EN
        if (r > 524287)  r = 524287;
        if (r < -524288) r = -524288;
`endif
        return r[OB-1:0];
    endfunction

    task automatic wr(input int idx, input logic signed [TB-1:0] re,
                      input logic signed [TB-1:0] im);
        bus.in_valid = 1'b1;
        bus.in_index = idx[7:0];
        bus.in_real  = re;
        bus.in_imag  = im;
        chk("in_ready_fill", bus.in_ready, 1);
        chk("no_beat_during_fill", bus.out_valid, 0);
        m_re[idx] = re;
        m_im[idx] = im;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Called one step after the edge that accepted the 256th write.
    task automatic drain(input bit toggle);
        int cyc = 0;
        int beats = 0;
        int first = -1;
        bit stalled = 0;
        logic signed [OB-1:0] h_re, h_im;
        logic [7:0] h_idx;
        beat_t e;
        for (int i = 0; i < 256; i++)
            sb.push_back('{i, exp_narrow(m_re[i]), exp_narrow(m_im[i])});
        bus.out_ready = 1'b1;
        while (beats < 256 && cyc < 3000) begin
            if (stalled) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_index", bus.out_index, h_idx);
                chk("stall_real", bus.out_real, h_re);
                chk("stall_imag", bus.out_imag, h_im);
            end
            stalled = 0;
            chk("in_ready_drain", bus.in_ready, 0);
            chk("frame_done_early", bus.frame_done, 0);
            if (bus.out_valid) begin
                if (first < 0) first = cyc;
                if (bus.out_ready) begin
                    e = sb.pop_front();
                    chk("beat_index", bus.out_index, e.idx);
                    chk("beat_real", bus.out_real, e.re);
                    chk("beat_imag", bus.out_imag, e.im);
                    chk("beat_last", bus.out_last, (e.idx == 255));
                    beats++;
                end else begin
                    stalled = 1;
                    h_re = bus.out_real;
                    h_im = bus.out_imag;
                    h_idx = bus.out_index;
                end
            end
            @(posedge clk); #1;
            cyc++;
            bus.out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
        end
        chk("beat_count", beats, 256);
        chk("first_beat_latency", first, 2);
        chk("frame_done_pulse", bus.frame_done, 1);
        chk("valid_after_frame", bus.out_valid, 0);
        chk("last_after_frame", bus.out_last, 0);
        chk("in_ready_after_frame", bus.in_ready, 1);
        sb.delete();
        @(posedge clk); #1;
        chk("frame_done_one_cycle", bus.frame_done, 0);
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        #2;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_out_index", bus.out_index, 0);
        chk("rst_out_real", bus.out_real, 0);
        chk("rst_out_imag", bus.out_imag, 0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] a, b;
        logic signed [TB-1:0] sp [6];

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_index = '0;
        bus.in_real = '0;
        bus.in_imag = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        do_reset();

        // Ordered fill, free-running drain
        for (int i = 0; i < 256; i++) wr(i, TB'(4 * i), TB'(-4 * i));
        drain(1'b0);

        // Bit-reversed fill, out_ready toggling every cycle
        for (int i = 0; i < 256; i++) begin
            a = i[7:0];
            for (int k = 0; k < 8; k++) b[k] = a[7-k];
            wr(int'(b), TB'(12 * int'(b) + 1), TB'(-8 * int'(b) - 3));
        end
        drain(1'b1);

        // Rounding and overflow entries
        sp[0] = 30'sd6;  sp[1] = -30'sd6;  sp[2] = 30'sd5;
        sp[3] = -30'sd5; sp[4] = 30'sd4194300; sp[5] = -30'sd4194308;
        for (int i = 0; i < 256; i++) begin
            if (i < 6) wr(i, sp[i], -sp[i]);
            else       wr(i, TB'(i * 1000 - 77), TB'(3 - i * 999));
        end
        drain(1'b0);

        // Reset after 100 writes, then a complete new frame of 7*4
        for (int i = 0; i < 100; i++) wr(i, TB'(1000 + i), TB'(-1000 - i));
        do_reset();
        for (int i = 0; i < 256; i++) wr(255 - i, 30'sd28, 30'sd28);
        drain(1'b0);

        // Write held through DRAIN becomes write 1 of the next frame
        for (int i = 0; i < 256; i++) wr(i, TB'(4 * i + 2), TB'(-4 * i - 1));
        bus.in_valid = 1'b1;
        bus.in_index = 8'd255;
        bus.in_real = 30'sd400;
        bus.in_imag = -30'sd400;
        drain(1'b0);
        bus.in_valid = 1'b0;
        m_re[255] = 30'sd400;
        m_im[255] = -30'sd400;
        for (int i = 0; i < 255; i++) wr(i, TB'(i * 8 + 3), TB'(-i * 8));
        drain(1'b0);

        // Reset in the middle of DRAIN
        for (int i = 0; i < 256; i++) wr(i, TB'(i), TB'(-i));
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        do_reset();
        for (int i = 0; i < 256; i++) wr(i, TB'(16 * i), TB'(5 - 16 * i));
        drain(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
